// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Latency XLEN+1 cycles (1 for div-by-zero/overflow); start is ignored while busy.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          f3_q, f3_d;
    logic                sa_q, sa_d, sb_q, sb_d;
    logic [XLEN-1:0]     mag_q, mag_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                busy_q, busy_d, done_q, done_d;

    logic                a_signed, b_signed, in_sa, in_sb, div_zero, div_ovf, last;
    logic [XLEN-1:0]     in_mag_a, in_mag_b;
    logic [XLEN:0]       mul_sum, div_shift, div_diff;
    logic                div_ok;
    logic [2*XLEN-1:0]   mul_next, div_next, prod_s;
    logic [XLEN-1:0]     mul_res, div_res, quo, rem;

    assign a_signed = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    assign b_signed = a_signed && (funct3 != 3'b010);
    assign in_sa    = a_signed & op_a[XLEN-1];
    assign in_sb    = b_signed & op_b[XLEN-1];
    assign in_mag_a = in_sa ? -op_a : op_a;
    assign in_mag_b = in_sb ? -op_b : op_b;
    assign div_zero = (op_b == '0);
    assign div_ovf  = ~funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    assign last     = (cnt_q == CNT_W'(XLEN-1));

    // Multiply: acc = {partial high, remaining multiplier bits}, shifted right each step
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
    assign prod_s   = (sa_q ^ sb_q) ? -mul_next : mul_next;
    assign mul_res  = (f3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];

    // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step
    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, mag_q};
    assign div_ok    = ~div_diff[XLEN];
    assign div_next  = {div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0], acc_q[XLEN-2:0], div_ok};
    assign quo       = div_next[XLEN-1:0];
    assign rem       = div_next[2*XLEN-1:XLEN];
    assign div_res   = f3_q[1] ? (sa_q ? -rem : rem) : ((sa_q ^ sb_q) ? -quo : quo);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        mag_d    = mag_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    state_d  = S_DONE;
                    result_d = mul_res;
                end
            end
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    state_d  = S_DONE;
                    result_d = div_res;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (start) begin
                    f3_d  = funct3;
                    sa_d  = in_sa;
                    sb_d  = in_sb;
                    cnt_d = '0;
                    if (funct3[2] && div_zero) begin
                        state_d  = S_DONE;
                        result_d = funct3[1] ? op_a : '1;
                    end else if (funct3[2] && div_ovf) begin
                        state_d  = S_DONE;
                        result_d = funct3[1] ? '0 : op_a;
                    end else if (funct3[2]) begin
                        state_d = S_DIV;
                        mag_d   = in_mag_b;
                        acc_d   = {{XLEN{1'b0}}, in_mag_a};
                    end else begin
                        state_d = S_MUL;
                        mag_d   = in_mag_a;
                        acc_d   = {{XLEN{1'b0}}, in_mag_b};
                    end
                end
            end
        endcase
        busy_d = (state_d == S_MUL) || (state_d == S_DIV);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            mag_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            mag_q    <= mag_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
